gate_truth_table_sequencer: RTL

- Drives every input combination into a 2-input switch-level gate cell under test, such as the CMOS NAND/NOR universal-gate cells.
- Samples the cell's output after a programmable settle time and assembles a 4-bit truth table.
- Classifies the truth table into a logic-function code.
- Sits directly around the gate cell: it is upstream because it feeds `a` and `b`, and downstream because it consumes `y`. It is the bench-style characterisation stage for the universal-switch cells.

---
 rtl/gate_truth_table_sequencer_if.sv | 43 ++++
 rtl/gate_truth_table_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/gate_truth_table_sequencer_if.sv
// Bundle of the signals exchanged between the truth-table sequencer and its
// surroundings: the start request, the gate-cell stimulus/response pair and
// the characterisation results.
interface gate_truth_table_sequencer_if;
  logic       start;
  logic       gate_y;
  logic       gate_a;
  logic       gate_b;
  logic       busy;
  logic       done;
  logic [3:0] truth_table;
  logic [2:0] func_code;
  logic       is_universal;
  logic       unstable;

  // Sequencer side: consumes start and the cell output, drives everything else.
  modport slave (
    input  start,
    input  gate_y,
    output gate_a,
    output gate_b,
    output busy,
    output done,
    output truth_table,
    output func_code,
    output is_universal,
    output unstable
  );

  // Environment side: issues start, provides the cell output, observes results.
  modport master (
    output start,
    output gate_y,
    input  gate_a,
    input  gate_b,
    input  busy,
    input  done,
    input  truth_table,
    input  func_code,
    input  is_universal,
    input  unstable
  );
endinterface

// File: rtl/gate_truth_table_sequencer.sv
// Characterisation sequencer for 2-input switch-level gate cells. Steps the
// cell through all four input vectors, samples its output twice per vector
// after a settle time, builds a 4-bit truth table and classifies it.
module gate_truth_table_sequencer #(
  parameter int SETTLE_CYCLES = 2
) (
  input logic clk,
  input logic rst_n,
  gate_truth_table_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, DRIVE, S1, S2, DONE} state_t;

  // Last counter value spent in DRIVE; the counter starts at 0 on entry.
  localparam logic [7:0] CNT_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic       s1;

  logic [1:0] idx_inc;
  logic [3:0] tt_upd;
  logic       unstable_upd;
  logic [2:0] code_upd;

  // Map a completed truth table (bit index = {a,b}) onto a function code.
  function automatic logic [2:0] classify(input logic [3:0] tt);
    logic [2:0] code;
    case (tt)
      4'b0111: code = 3'd1; // NAND
      4'b0001: code = 3'd2; // NOR
      4'b1000: code = 3'd3; // AND
      4'b1110: code = 3'd4; // OR
      4'b0110: code = 3'd5; // XOR
      4'b1001: code = 3'd6; // XNOR
      default: code = 3'd0;
    endcase
    return code;
  endfunction

  // Results as they will look once the current S2 sample is folded in, so the
  // classification can be registered on the same edge that enters DONE.
  always_comb begin
    idx_inc          = idx + 2'd1;
    tt_upd           = bus.truth_table;
    tt_upd[idx]      = bus.gate_y;
    unstable_upd     = bus.unstable | (bus.gate_y != s1);
    code_upd         = unstable_upd ? 3'd0 : classify(tt_upd);
  end

  // Main sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      idx              <= 2'd0;
      cnt              <= 8'd0;
      s1               <= 1'b0;
      bus.gate_a       <= 1'b0;
      bus.gate_b       <= 1'b0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.truth_table  <= 4'd0;
      bus.func_code    <= 3'd0;
      bus.is_universal <= 1'b0;
      bus.unstable     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.gate_a <= 1'b0;
          bus.gate_b <= 1'b0;
          bus.done   <= 1'b0;
          if (bus.start) begin
            state            <= DRIVE;
            idx              <= 2'd0;
            cnt              <= 8'd0;
            bus.busy         <= 1'b1;
            bus.truth_table  <= 4'd0;
            bus.func_code    <= 3'd0;
            bus.is_universal <= 1'b0;
            bus.unstable     <= 1'b0;
          end
        end
        DRIVE: begin
          cnt <= cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            state <= S1;
          end
        end
        S1: begin
          s1    <= bus.gate_y;
          state <= S2;
        end
        S2: begin
          bus.truth_table <= tt_upd;
          bus.unstable    <= unstable_upd;
          if (idx == 2'd3) begin
            state            <= DONE;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
            bus.gate_a       <= 1'b0;
            bus.gate_b       <= 1'b0;
            bus.func_code    <= code_upd;
            bus.is_universal <= (code_upd == 3'd1) || (code_upd == 3'd2);
          end else begin
            state                    <= DRIVE;
            idx                      <= idx_inc;
            cnt                      <= 8'd0;
            {bus.gate_a, bus.gate_b} <= idx_inc;
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
